// File: rtl/iot_monitor_param_if.sv
// Interface bundling the count-control inputs and status outputs of
// iot_monitor_param. The optional peak-tracking signals appear only when
// PEAK_TRACK_EN is defined.
interface iot_monitor_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              change;
    logic              on_off;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic [WIDTH-1:0]  counter_out;
    logic              limit_hit;
    logic              alarm;
`ifdef PEAK_TRACK_EN
    logic              peak_clr;
    logic [WIDTH-1:0]  peak_out;

    modport master (
        output change, on_off, step, sat_mode, load, load_value, peak_clr,
        input  counter_out, limit_hit, alarm, peak_out
    );

    modport slave (
        input  change, on_off, step, sat_mode, load, load_value, peak_clr,
        output counter_out, limit_hit, alarm, peak_out
    );
`else
    modport master (
        output change, on_off, step, sat_mode, load, load_value,
        input  counter_out, limit_hit, alarm
    );

    modport slave (
        input  change, on_off, step, sat_mode, load, load_value,
        output counter_out, limit_hit, alarm
    );
`endif
endinterface

// File: rtl/iot_monitor_param.sv
// Active-IoT-device counter with multi-device step, wrap/saturate overflow
// handling, synchronous preload and a hysteresis alarm.
// Optional peak tracking is enabled by defining PEAK_TRACK_EN.
module iot_monitor_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int HI_TH  = 200,
    parameter int LO_TH  = 100
) (
    input logic               clk,
    input logic               rst,
    iot_monitor_param_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] HI_VAL  = WIDTH'(HI_TH);
    localparam logic [WIDTH-1:0] LO_VAL  = WIDTH'(LO_TH);

    typedef enum logic {
        NORMAL = 1'b0,
        HIGH   = 1'b1
    } state_t;

    logic [WIDTH-1:0] count_q;
    logic             limit_q;
    logic             alarm_q;
    state_t           state;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // One extra bit on both paths exposes carry (up) and borrow (down).
    always_comb begin
        step_ext = (WIDTH+1)'(bus.step);
        sum      = {1'b0, count_q} + step_ext;
        diff     = {1'b0, count_q} - step_ext;
    end

    // Counter update: load beats change; overflow either clips or wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            limit_q <= 1'b0;
        end else if (bus.load) begin
            count_q <= bus.load_value;
            limit_q <= 1'b0;
        end else if (bus.change) begin
            if (bus.on_off) begin
                limit_q <= sum[WIDTH];
                if (sum[WIDTH] && bus.sat_mode)
                    count_q <= MAX_VAL;
                else
                    count_q <= sum[WIDTH-1:0];
            end else begin
                limit_q <= diff[WIDTH];
                if (diff[WIDTH] && bus.sat_mode)
                    count_q <= '0;
                else
                    count_q <= diff[WIDTH-1:0];
            end
        end else begin
            limit_q <= 1'b0;
        end
    end

    // Hysteresis alarm FSM, looking at the registered count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= NORMAL;
            alarm_q <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (count_q >= HI_VAL) begin
                        state   <= HIGH;
                        alarm_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (count_q <= LO_VAL) begin
                        state   <= NORMAL;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= NORMAL;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.counter_out = count_q;
    assign bus.limit_hit   = limit_q;
    assign bus.alarm       = alarm_q;

`ifdef PEAK_TRACK_EN
    logic [WIDTH-1:0] peak_q;

    // Running maximum of the count; a clear restarts it from the current count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            peak_q <= '0;
        else if (bus.peak_clr)
            peak_q <= count_q;
        else if (count_q > peak_q)
            peak_q <= count_q;
    end

    assign bus.peak_out = peak_q;
`endif

endmodule
